stopwatch_core: RTL and testbench

Parametrised stopwatch timing core: divides the board clock down to a configurable tick rate, then runs a chain of mixed-radix digit counters. Adds start/stop, clear, lap-freeze and overflow handling. Sits between the button conditioners and the multiplexed seven-segment display driver, replacing the fixed free-running seconds/minutes chain.

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/stopwatch_core_digit_counter.sv | 29 ++
 rtl/stopwatch_core.sv | 182 ++++++++++++++++++
 tb/tb_stopwatch_core.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timing core.
// Digit radices are packed 4 bits per digit, digit 0 in the LSBs.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam int BCD_W = 4;

    // mm:ss.cc -> bases 6,10 : 6,10 : 10,10 from MSB to LSB
    localparam logic [23:0] SW_DEFAULT_BASES = {4'd6, 4'd10, 4'd6, 4'd10, 4'd10, 4'd10};

    function automatic bit bases_valid(input logic [31:0] bases, input int num_digits);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < num_digits) begin
                if (bases[4*i +: 4] < 4'd2 || bases[4*i +: 4] > 4'd10) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/stopwatch_core_digit_counter.sv
// One mixed-radix BCD digit: counts 0..BASE-1 on inc, wraps to 0 from BASE-1.
module digit_counter
    import stopwatch_pkg::*;
#(
    parameter int BASE = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] value,
    output logic             at_max
);

    localparam logic [BCD_W-1:0] MAX_VAL = BCD_W'(BASE - 1);

    assign at_max = (value == MAX_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= at_max ? '0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: prescaler, run/pause FSM, digit chain, lap freeze and overflow.
// Event priority in one cycle is clear, then start_stop, then lap.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int                            CLK_FREQ_HZ = 100_000_000,
    parameter int                            TICK_HZ     = 100,
    parameter int                            NUM_DIGITS  = 6,
    parameter logic [BCD_W*NUM_DIGITS-1:0]   DIGIT_BASES = SW_DEFAULT_BASES,
    parameter bit                            WRAP        = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_stop,
    input  logic                          lap,
    input  logic                          clear,
    output logic                          running,
    output logic                          lap_active,
    output logic                          overflow,
    output logic                          tick,
    output logic [BCD_W*NUM_DIGITS-1:0]   live,
    output logic [BCD_W*NUM_DIGITS-1:0]   digits,
    output sw_state_t                     state
);

    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_PAUSE = PAUSE;

    if ((CLK_FREQ_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
        $error("stopwatch_core: CLK_FREQ_HZ / TICK_HZ must be exact and at least 2");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("stopwatch_core: NUM_DIGITS must be 1..8");
    end
    if (!bases_valid(32'(DIGIT_BASES), NUM_DIGITS)) begin : g_bad_bases
        $error("stopwatch_core: every digit base must be 2..10");
    end

    logic [1:0]                    state_q, state_d;
    logic [PRE_W-1:0]              pre_q;
    logic [NUM_DIGITS-1:0]         at_max;
    logic [NUM_DIGITS-1:0]         digit_inc;
    logic [BCD_W*NUM_DIGITS-1:0]   live_w;
    logic [BCD_W*NUM_DIGITS-1:0]   live_next;
    logic                          in_run;
    logic                          pre_done;
    logic                          all_max;
    logic                          saturate;
    logic                          count_inc;
    logic                          ss_ev;
    logic                          lap_ev;
    logic                          running_q, lap_active_q, overflow_q, tick_q;
    logic [BCD_W*NUM_DIGITS-1:0]   disp_q;

    always_comb begin
        in_run    = (state_q == ST_RUN);
        pre_done  = in_run && (pre_q == PRE_LAST);
        all_max   = &at_max;
        // Saturation: a pending increment at full count with wrapping disabled
        saturate  = pre_done && all_max && !WRAP;
        count_inc = pre_done && !clear && !saturate;
        ss_ev     = start_stop && !clear;
        lap_ev    = lap && !clear && !start_stop;
    end

    always_comb begin
        logic carry;
        carry = count_inc;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_inc[i] = carry;
            carry        = carry & at_max[i];
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [BCD_W-1:0] value;

        digit_counter #(
            .BASE (int'(DIGIT_BASES[BCD_W*i +: BCD_W]))
        ) u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clear),
            .inc    (digit_inc[i]),
            .value  (value),
            .at_max (at_max[i])
        );

        assign live_w[BCD_W*i +: BCD_W]    = value;
        assign live_next[BCD_W*i +: BCD_W] = clear        ? '0 :
                                             digit_inc[i] ? (at_max[i] ? '0 : value + 4'd1) :
                                                            value;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (ss_ev) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                // A saturated count cannot be resumed; only clear leaves it
                ST_PAUSE: state_d = (!WRAP && all_max) ? ST_PAUSE : ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end else if (saturate) begin
            state_d = ST_PAUSE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    // Prescaler holds in PAUSE so a resume keeps the fractional tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (clear) begin
            pre_q <= '0;
        end else if (ss_ev && state_q == ST_IDLE) begin
            pre_q <= '0;
        end else if (in_run) begin
            pre_q <= pre_done ? '0 : pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            tick_q     <= 1'b0;
        end else if (clear) begin
            overflow_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            if (pre_done && all_max) begin
                overflow_q <= 1'b1;
            end
            tick_q <= count_inc;
        end
    end

    // The displayed register doubles as the lap snapshot while frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_active_q <= 1'b0;
            disp_q       <= '0;
        end else if (clear) begin
            lap_active_q <= 1'b0;
            disp_q       <= '0;
        end else if (lap_ev && !lap_active_q) begin
            lap_active_q <= 1'b1;
            disp_q       <= live_w;
        end else if (lap_ev) begin
            lap_active_q <= 1'b0;
            disp_q       <= live_next;
        end else if (!lap_active_q) begin
            disp_q       <= live_next;
        end
    end

    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign overflow   = overflow_q;
    assign tick       = tick_q;
    assign live       = live_w;
    assign digits     = disp_q;
    assign state      = sw_state_t'(state_q);

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: timing, pause, lap, carry, overflow, clear and reset.
module tb_stopwatch_core;
    import stopwatch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance: 6 digits, default bases, wrapping
    logic        ss0, lap0, clr0;
    logic        running0, lap_active0, overflow0, tick0;
    logic [23:0] live0, digits0;
    sw_state_t   state0;

    // Two-digit instances, bases {6,10}: u1 wraps, u2 saturates
    logic        ss1, ss2, clr12, lap12;
    logic        running1, lap_active1, overflow1, tick1;
    logic        running2, lap_active2, overflow2, tick2;
    logic [7:0]  live1, digits1, live2, digits2;
    sw_state_t   state1, state2;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_core #(
        .CLK_FREQ_HZ(10), .TICK_HZ(1), .NUM_DIGITS(6),
        .DIGIT_BASES(24'h6A6AAA), .WRAP(1'b1)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .start_stop(ss0), .lap(lap0), .clear(clr0),
        .running(running0), .lap_active(lap_active0), .overflow(overflow0), .tick(tick0),
        .live(live0), .digits(digits0), .state(state0)
    );

    stopwatch_core #(
        .CLK_FREQ_HZ(10), .TICK_HZ(1), .NUM_DIGITS(2),
        .DIGIT_BASES(8'h6A), .WRAP(1'b1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .start_stop(ss1), .lap(lap12), .clear(clr12),
        .running(running1), .lap_active(lap_active1), .overflow(overflow1), .tick(tick1),
        .live(live1), .digits(digits1), .state(state1)
    );

    stopwatch_core #(
        .CLK_FREQ_HZ(10), .TICK_HZ(1), .NUM_DIGITS(2),
        .DIGIT_BASES(8'h6A), .WRAP(1'b0)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .start_stop(ss2), .lap(lap12), .clear(clr12),
        .running(running2), .lap_active(lap_active2), .overflow(overflow2), .tick(tick2),
        .live(live2), .digits(digits2), .state(state2)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ss0 = 0; lap0 = 0; clr0 = 0;
        ss1 = 0; ss2 = 0; clr12 = 0; lap12 = 0;
        step(2);
        rst_n = 1'b1;
        step(1);

        // Reset state
        check("rst running",    running0,    0);
        check("rst lap_active", lap_active0, 0);
        check("rst overflow",   overflow0,   0);
        check("rst tick",       tick0,       0);
        check("rst live",       live0,       0);
        check("rst digits",     digits0,     0);
        check("rst state",      state0,      IDLE);

        // Two-digit wrap / saturate
        ss1 = 1; ss2 = 1;
        step();
        ss1 = 0; ss2 = 0;
        check("u1 running", running1, 1);
        check("u2 running", running2, 1);
        for (int k = 0; k < 700 && live1 !== 8'h59; k++) step();
        check("u1 reach 59", live1, 8'h59);
        check("u2 reach 59", live2, 8'h59);
        step(9);
        check("u1 ovf before max inc", overflow1, 0);
        step();
        check("u1 wrap live",      live1,     8'h00);
        check("u1 wrap overflow",  overflow1, 1);
        check("u1 wrap tick",      tick1,     1);
        check("u1 wrap running",   running1,  1);
        check("u2 sat live",       live2,     8'h59);
        check("u2 sat overflow",   overflow2, 1);
        check("u2 sat state",      state2,    PAUSE);
        check("u2 sat running",    running2,  0);
        check("u2 sat tick",       tick2,     0);
        ss2 = 1;
        step();
        ss2 = 0;
        check("u2 ss ignored state",   state2,   PAUSE);
        check("u2 ss ignored running", running2, 0);
        step(20);
        check("u2 held live",        live2,     8'h59);
        check("u1 counts after wrap", live1,    8'h02);
        check("u1 overflow sticky",  overflow1, 1);
        clr12 = 1;
        step();
        clr12 = 0;
        check("u1 clr overflow", overflow1, 0);
        check("u1 clr live",     live1,     0);
        check("u1 clr running",  running1,  0);
        check("u2 clr overflow", overflow2, 0);
        check("u2 clr live",     live2,     0);
        check("u2 clr state",    state2,    IDLE);

        // First tick timing (cycle numbers relative to the start_stop cycle)
        ss0 = 1;
        step();
        ss0 = 0;
        check("c1 running", running0, 1);
        check("c1 state",   state0,   RUN);
        step(9);
        check("c10 tick", tick0, 0);
        check("c10 live", live0, 24'h000000);
        step();
        check("c11 tick", tick0, 1);
        check("c11 live", live0, 24'h000001);
        step();
        check("c12 tick", tick0, 0);
        step(89);
        check("c101 live", live0, 24'h000010);
        check("c101 tick", tick0, 1);

        // Pause at pre=4, resume keeps fractional tick
        step(4);
        ss0 = 1;
        step();
        ss0 = 0;
        check("pause running", running0, 0);
        check("pause state",   state0,   PAUSE);
        step(50);
        check("pause live held", live0,    24'h000010);
        check("pause tick",      tick0,    0);
        ss0 = 1;
        step();
        ss0 = 0;
        check("resume running", running0, 1);
        step(4);
        check("resume +5 tick", tick0, 0);
        check("resume +5 live", live0, 24'h000010);
        step();
        check("resume +6 tick", tick0, 1);
        check("resume +6 live", live0, 24'h000011);

        // Lap captured on the same edge as an increment
        step(60);
        check("pre-lap live", live0, 24'h000017);
        step(9);
        lap0 = 1;
        step();
        lap0 = 0;
        check("lap active",   lap_active0, 1);
        check("lap snapshot", digits0,     24'h000017);
        check("lap live inc", live0,       24'h000018);
        step(30);
        check("lap live runs",  live0,   24'h000021);
        check("lap digits hold", digits0, 24'h000017);
        lap0 = 1;
        step();
        lap0 = 0;
        check("unlap active", lap_active0, 0);
        check("unlap digits", digits0,     24'h000021);
        step(9);
        check("unlap track digits", digits0, 24'h000022);
        check("unlap track live",   live0,   24'h000022);

        // Carry through every digit below the minutes
        for (int k = 0; k < 60000 && live0 !== 24'h005999; k++) step();
        check("reach 005999", live0, 24'h005999);
        step(9);
        check("hold 005999", live0, 24'h005999);
        step();
        check("carry live",     live0,     24'h010000);
        check("carry digits",   digits0,   24'h010000);
        check("carry tick",     tick0,     1);
        check("carry overflow", overflow0, 0);

        // clear + start_stop + lap together while running and lapped
        lap0 = 1;
        step();
        lap0 = 0;
        check("pre-clear lap", lap_active0, 1);
        clr0 = 1; ss0 = 1; lap0 = 1;
        step();
        clr0 = 0; ss0 = 0; lap0 = 0;
        check("clr state",      state0,      IDLE);
        check("clr running",    running0,    0);
        check("clr live",       live0,       0);
        check("clr digits",     digits0,     0);
        check("clr lap_active", lap_active0, 0);
        check("clr tick",       tick0,       0);
        step(15);
        check("idle no count", live0, 0);

        // Asynchronous reset mid-count
        ss0 = 1;
        step();
        ss0 = 0;
        step(25);
        check("pre-rst live", live0, 24'h000002);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst running",  running0, 0);
        check("arst live",     live0,    0);
        check("arst digits",   digits0,  0);
        check("arst state",    state0,   IDLE);
        check("arst overflow", overflow0, 0);
        check("arst tick",     tick0,    0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("post-rst live", live0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
